// File: rtl/trigger_pulse_gen_if.sv
// ---------------------------------------------------------------------------
// trigger_pulse_gen_if
// Bundle of per-channel control and status signals for trigger_pulse_gen.
//   master : sequencer side. Drives trigger/enable/config/clear and
//            observes q/busy/overrun.
//   slave  : the pulse generator itself.
// Signals (all packed, one bit or one field per channel):
//   trigger, enable, retrigger, overrun_clear : CHANNELS bits
//   delay     : CHANNELS*DELAY_WIDTH, channel i at [i*DELAY_WIDTH +: DELAY_WIDTH]
//   pulse_len : CHANNELS*LEN_WIDTH, same packing
//   q, busy, overrun : CHANNELS bits, registered in the generator
// ---------------------------------------------------------------------------
interface trigger_pulse_gen_if #(
   parameter int CHANNELS    = 4,
   parameter int DELAY_WIDTH = 16,
   parameter int LEN_WIDTH   = 16
);
   logic [CHANNELS-1:0]             trigger;
   logic [CHANNELS-1:0]             enable;
   logic [CHANNELS*DELAY_WIDTH-1:0] delay;
   logic [CHANNELS*LEN_WIDTH-1:0]   pulse_len;
   logic [CHANNELS-1:0]             retrigger;
   logic [CHANNELS-1:0]             overrun_clear;
   logic [CHANNELS-1:0]             q;
   logic [CHANNELS-1:0]             busy;
   logic [CHANNELS-1:0]             overrun;

   modport master (
      output trigger, enable, delay, pulse_len, retrigger, overrun_clear,
      input  q, busy, overrun
   );

   modport slave (
      input  trigger, enable, delay, pulse_len, retrigger, overrun_clear,
      output q, busy, overrun
   );
endinterface

// File: rtl/trigger_pulse_gen.sv
// ---------------------------------------------------------------------------
// trigger_pulse_gen
// Multi-channel trigger-to-pulse generator. Each channel detects a rising
// edge on its trigger, waits a latched delay D, then drives q for a latched
// length L = max(pulse_len, 1). Edges arriving while busy are either
// ignored (flagging a sticky overrun) or restart the channel, per channel.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : trigger_pulse_gen_if.slave (trigger, enable, delay, pulse_len,
//           retrigger, overrun_clear in; q, busy, overrun out)
// Contains trigger_pulse_ch, the per-channel engine, instantiated once per
// channel through a generate loop.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// trigger_pulse_ch
// One channel: edge detect, IDLE/DELAY/PULSE FSM, single down-counter,
// sticky overrun flag. All outputs registered.
// Ports:
//   i_trigger, i_enable, i_retrigger, i_ovr_clr : channel controls
//   i_delay, i_len : channel config, sampled only on an accepted edge
//   o_q, o_busy, o_overrun : registered status
// ---------------------------------------------------------------------------
module trigger_pulse_ch #(
   parameter int DELAY_WIDTH = 16,
   parameter int LEN_WIDTH   = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   i_trigger,
   input  logic                   i_enable,
   input  logic [DELAY_WIDTH-1:0] i_delay,
   input  logic [LEN_WIDTH-1:0]   i_len,
   input  logic                   i_retrigger,
   input  logic                   i_ovr_clr,
   output logic                   o_q,
   output logic                   o_busy,
   output logic                   o_overrun
);
   // One counter serves both phases, so it is as wide as the wider field.
   localparam int CW = (DELAY_WIDTH > LEN_WIDTH) ? DELAY_WIDTH : LEN_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_DELAY, S_PULSE} state_t;

   state_t               r_state;
   logic [CW-1:0]        r_cnt;
   logic [LEN_WIDTH-1:0] r_len;      // latched effective length, never 0
   logic                 r_trig_prev;
   logic                 r_q;
   logic                 r_busy;
   logic                 r_overrun;

   logic                 w_edge;
   logic                 w_busy;
   logic                 w_start;
   logic                 w_ovr_set;
   logic [LEN_WIDTH-1:0] w_len_eff;

   assign w_edge    = i_trigger & ~r_trig_prev & i_enable;
   assign w_busy    = (r_state != S_IDLE);
   // Edge while busy restarts only with retrigger; otherwise it is dropped
   // and remembered in the sticky overrun flag.
   assign w_start   = w_edge & (~w_busy | i_retrigger);
   assign w_ovr_set = w_edge & w_busy & ~i_retrigger;
   assign w_len_eff = (i_len == '0) ? LEN_WIDTH'(1) : i_len;

   // The counter holds "cycles remaining minus one" so that D and L up to
   // their full-scale values are exact without an extra counter bit.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_len       <= '0;
         r_trig_prev <= 1'b1;   // trigger held through reset is not an edge
         r_q         <= 1'b0;
         r_busy      <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_trig_prev <= i_trigger;

         // set has priority over clear
         if (w_ovr_set)
            r_overrun <= 1'b1;
         else if (i_ovr_clr)
            r_overrun <= 1'b0;

         if (!i_enable) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_q     <= 1'b0;
            r_busy  <= 1'b0;
         end else if (w_start) begin
            r_len  <= w_len_eff;
            r_busy <= 1'b1;
            if (i_delay != '0) begin
               r_state <= S_DELAY;
               r_cnt   <= CW'(i_delay) - CW'(1);
               r_q     <= 1'b0;
            end else begin
               r_state <= S_PULSE;
               r_cnt   <= CW'(w_len_eff) - CW'(1);
               r_q     <= 1'b1;
            end
         end else begin
            case (r_state)
               S_DELAY: begin
                  if (r_cnt == '0) begin
                     r_state <= S_PULSE;
                     r_cnt   <= CW'(r_len) - CW'(1);
                     r_q     <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt - CW'(1);
                  end
               end
               S_PULSE: begin
                  if (r_cnt == '0) begin
                     r_state <= S_IDLE;
                     r_q     <= 1'b0;
                     r_busy  <= 1'b0;
                  end else begin
                     r_cnt <= r_cnt - CW'(1);
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  r_q     <= 1'b0;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign o_q       = r_q;
   assign o_busy    = r_busy;
   assign o_overrun = r_overrun;
endmodule

module trigger_pulse_gen #(
   parameter int CHANNELS    = 4,
   parameter int DELAY_WIDTH = 16,
   parameter int LEN_WIDTH   = 16
) (
   input  logic               clock,
   input  logic               reset,
   trigger_pulse_gen_if.slave bus
);
   logic [CHANNELS-1:0] w_q;
   logic [CHANNELS-1:0] w_busy;
   logic [CHANNELS-1:0] w_overrun;

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      trigger_pulse_ch #(
         .DELAY_WIDTH (DELAY_WIDTH),
         .LEN_WIDTH   (LEN_WIDTH)
      ) u_ch (
         .clock       (clock),
         .reset       (reset),
         .i_trigger   (bus.trigger[gi]),
         .i_enable    (bus.enable[gi]),
         .i_delay     (bus.delay[gi*DELAY_WIDTH +: DELAY_WIDTH]),
         .i_len       (bus.pulse_len[gi*LEN_WIDTH +: LEN_WIDTH]),
         .i_retrigger (bus.retrigger[gi]),
         .i_ovr_clr   (bus.overrun_clear[gi]),
         .o_q         (w_q[gi]),
         .o_busy      (w_busy[gi]),
         .o_overrun   (w_overrun[gi])
      );
   end

   assign bus.q       = w_q;
   assign bus.busy    = w_busy;
   assign bus.overrun = w_overrun;
endmodule

// File: tb/tb_trigger_pulse_gen.sv
// Cycle t of a scenario: inputs from the stimulus tables are applied just
// after posedge t, and the outputs visible during cycle t are compared at the
// following negedge against expectations computed from the timing rules
// (q high N+1+D .. N+D+L, busy high N+1 .. N+D+L for an edge in cycle N).
module tb_trigger_pulse_gen;
   localparam int CH = 4, DW = 12, LW = 12, MAXT = 8200;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   trigger_pulse_gen_if #(.CHANNELS(CH), .DELAY_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

   trigger_pulse_gen #(.CHANNELS(CH), .DELAY_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [CH-1:0] q, b, o;
      int            t;
      string         tag;
   } exp_t;
   exp_t sb[$];

   int n_vec = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h want=%0h", tag, act, exp);
      end
   endtask

   // stimulus and expectation tables
   logic [CH-1:0]    s_trig[MAXT], s_en[MAXT], s_rt[MAXT], s_clr[MAXT];
   logic             s_rst[MAXT];
   logic [CH*DW-1:0] s_dly[MAXT];
   logic [CH*LW-1:0] s_len[MAXT];
   logic [CH-1:0]    e_q[MAXT], e_b[MAXT], e_o[MAXT];

   task automatic clear_scn();
      for (int t = 0; t < MAXT; t++) begin
         s_trig[t] = '0; s_en[t] = '1; s_rt[t] = '0; s_clr[t] = '0;
         s_rst[t] = 1'b0; s_dly[t] = '0; s_len[t] = '0;
         e_q[t] = '0; e_b[t] = '0; e_o[t] = '0;
      end
   endtask

   task automatic set_cfg(input int ch, input int from, input int d, input int l);
      for (int t = from; t < MAXT; t++) begin
         s_dly[t][ch*DW +: DW] = d[DW-1:0];
         s_len[t][ch*LW +: LW] = l[LW-1:0];
      end
   endtask

   task automatic trig_hi(input int ch, input int a, input int b);
      for (int t = a; t <= b; t++) s_trig[t][ch] = 1'b1;
   endtask

   task automatic exp_pulse(input int ch, input int n, input int d, input int l);
      int len;
      len = (l == 0) ? 1 : l;
      for (int t = n + 1; t <= n + d + len && t < MAXT; t++) begin
         e_b[t][ch] = 1'b1;
         if (t >= n + 1 + d) e_q[t][ch] = 1'b1;
      end
   endtask

   task automatic exp_clr(input int ch, input int from);
      for (int t = from; t < MAXT; t++) begin
         e_q[t][ch] = 1'b0;
         e_b[t][ch] = 1'b0;
      end
   endtask

   task automatic exp_ovr(input int ch, input int a, input int b);
      for (int t = a; t <= b && t < MAXT; t++) e_o[t][ch] = 1'b1;
   endtask

   // Reset with every trigger held high: leaves trig_prev at ones.
   task automatic reset_dut();
      reset       = 1'b1;
      bus.trigger = '1;
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   task automatic run(input string tag, input int n);
      for (int t = 0; t < n; t++) begin
         reset             = s_rst[t];
         bus.trigger       = s_trig[t];
         bus.enable        = s_en[t];
         bus.retrigger     = s_rt[t];
         bus.overrun_clear = s_clr[t];
         bus.delay         = s_dly[t];
         bus.pulse_len     = s_len[t];
         sb.push_back('{q: e_q[t], b: e_b[t], o: e_o[t], t: t, tag: tag});
         @(posedge clock); #1;
      end
   endtask

   always @(negedge clock) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk($sformatf("%s.q@%0d", e.tag, e.t),    32'(bus.q),       32'(e.q));
         chk($sformatf("%s.busy@%0d", e.tag, e.t), 32'(bus.busy),    32'(e.b));
         chk($sformatf("%s.ovr@%0d", e.tag, e.t),  32'(bus.overrun), 32'(e.o));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      bus.trigger = '0; bus.enable = '1; bus.retrigger = '0;
      bus.overrun_clear = '0; bus.delay = '0; bus.pulse_len = '0;
      @(posedge clock); #1;

      // legacy one-cycle strobe, trigger held 5 cycles
      clear_scn();
      set_cfg(0, 0, 0, 1);
      trig_hi(0, 10, 14);
      exp_pulse(0, 10, 0, 1);
      reset_dut(); run("legacy", 30);

      // delay/length with mid-flight config change
      clear_scn();
      set_cfg(1, 0, 3, 4);
      set_cfg(1, 22, 100, 4);
      trig_hi(1, 20, 21);
      exp_pulse(1, 20, 3, 4);
      reset_dut(); run("dlylen", 40);

      // ch2 ignore policy + overrun clear + set-beats-clear; ch3 restart
      clear_scn();
      set_cfg(2, 0, 2, 5);
      set_cfg(3, 0, 2, 5);
      for (int t = 0; t < MAXT; t++) s_rt[t][3] = 1'b1;
      trig_hi(2, 2, 2); trig_hi(2, 6, 6);
      trig_hi(3, 2, 2); trig_hi(3, 6, 6);
      exp_pulse(2, 2, 2, 5);
      s_clr[12][2] = 1'b1;
      exp_ovr(2, 7, 12);
      trig_hi(2, 14, 14); trig_hi(2, 17, 17);
      s_clr[17][2] = 1'b1;
      exp_pulse(2, 14, 2, 5);
      exp_ovr(2, 18, MAXT - 1);
      exp_pulse(3, 2, 2, 5);
      exp_clr(3, 7);
      exp_pulse(3, 6, 2, 5);
      reset_dut(); run("policy", 25);

      // enable dropped during PULSE; overrun holds
      clear_scn();
      set_cfg(0, 0, 1, 6);
      trig_hi(0, 2, 2); trig_hi(0, 4, 4);
      for (int t = 6; t < MAXT; t++) s_en[t][0] = 1'b0;
      exp_pulse(0, 2, 1, 6);
      exp_clr(0, 7);
      exp_ovr(0, 5, MAXT - 1);
      reset_dut(); run("enable", 15);

      // reset mid-DELAY with trigger held; ch0 overrun cleared by reset
      clear_scn();
      set_cfg(0, 0, 3, 3);
      set_cfg(1, 0, 10, 3);
      trig_hi(0, 2, 2); trig_hi(0, 4, 4);
      trig_hi(1, 0, 1); trig_hi(1, 3, 19); trig_hi(1, 22, 39);
      s_rst[6] = 1'b1;
      exp_pulse(0, 2, 3, 3);
      exp_ovr(0, 5, 6);
      exp_clr(0, 7);
      exp_pulse(1, 3, 10, 3);
      exp_clr(1, 7);
      exp_pulse(1, 22, 10, 3);
      reset_dut(); run("midrst", 40);

      // all channels in the same cycle, including len=0
      clear_scn();
      set_cfg(0, 0, 0, 3);
      set_cfg(1, 0, 1, 1);
      set_cfg(2, 0, 5, 0);
      set_cfg(3, 0, 2, 2);
      for (int c = 0; c < CH; c++) trig_hi(c, 2, 3);
      exp_pulse(0, 2, 0, 3);
      exp_pulse(1, 2, 1, 1);
      exp_pulse(2, 2, 5, 0);
      exp_pulse(3, 2, 2, 2);
      reset_dut(); run("all4", 15);

      // full-scale delay and length
      clear_scn();
      set_cfg(3, 0, (1 << DW) - 1, (1 << LW) - 1);
      trig_hi(3, 2, 2);
      exp_pulse(3, 2, (1 << DW) - 1, (1 << LW) - 1);
      reset_dut(); run("maxdl", 8200);

      @(negedge clock);
      chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/trigger_pulse_gen.md
Name: trigger_pulse_gen

Overview:
Multi-channel trigger-to-pulse generator. It is the parametrised successor of the single-cycle trigger/strobe state machine. Each channel detects a rising edge on its trigger input, waits a programmable delay, then drives a pulse of programmable length. Per-channel enable, retrigger policy and sticky overrun flags let the sequencer/PC-interface logic gate experiment timing strobes (PMT gating, DDS/DAC update strobes).

Parameters:
CHANNELS, 4, number of independent channels
DELAY_WIDTH, 16, width of per-channel delay count
LEN_WIDTH, 16, width of per-channel pulse length count

Ports:
clock  input  1  system clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
trigger  input  CHANNELS  per-channel trigger level, synchronous to clock
enable  input  CHANNELS  per-channel enable; low forces channel idle
delay  input  CHANNELS*DELAY_WIDTH  per-channel delay in cycles; channel i at bits [i*DELAY_WIDTH +: DELAY_WIDTH]
pulse_len  input  CHANNELS*LEN_WIDTH  per-channel pulse length in cycles; same packing
retrigger  input  CHANNELS  per-channel policy: 0 = ignore edges while busy, 1 = restart on edge
overrun_clear  input  CHANNELS  per-channel clear of the overrun flag
q  output  CHANNELS  pulse outputs, registered
busy  output  CHANNELS  high while the channel is in DELAY or PULSE
overrun  output  CHANNELS  sticky flag: an edge was ignored while busy

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clock.
- Reset: q=0, busy=0, overrun=0, all channels IDLE, counters 0, trig_prev=all ones. A trigger held high through reset produces no edge.
- Edge detect per channel: edge = trigger & ~trig_prev & enable. trig_prev registers trigger every cycle, including while disabled.
- Per-channel FSM states:
  - IDLE (q=0, busy=0).
  - DELAY (q=0, busy=1).
  - PULSE (q=1, busy=1).
- Latching: on an accepted edge, delay and pulse_len are latched into the channel. Later input changes do not affect the pulse in flight.
- Effective length L = max(pulse_len, 1). pulse_len=0 behaves as 1.
- Edge sampled in cycle N with delay D:
  - q first high in cycle N+1+D and stays high for exactly L cycles.
  - busy high from N+1 through the last q-high cycle.
  - D=0, L=1 reproduces the legacy one-cycle strobe one clock after the trigger.
- Transitions:
  - IDLE -> DELAY when edge and D>0.
  - IDLE -> PULSE when edge and D=0.
  - DELAY -> PULSE after D cycles in DELAY.
  - PULSE -> IDLE after L cycles in PULSE.
- Edge while busy, retrigger=0:
  - Edge is ignored and the current pulse continues unchanged.
  - overrun is set the next cycle.
  - An edge in the last PULSE cycle is also ignored (the channel is not yet IDLE) and sets overrun.
- Edge while busy, retrigger=1:
  - New config is latched and the timing restarts exactly as from IDLE.
  - If the new D>0, q drops the next cycle.
  - overrun is not set.
- enable low: the channel goes to IDLE and q=0 from the next cycle. overrun holds its value.
- overrun_clear: clears overrun next cycle. If a set and a clear occur in the same cycle, set wins.
- Channels are fully independent. No cross-channel interaction, no shared counters.
- Counters saturate-free: max D = 2^DELAY_WIDTH-1 and max L = 2^LEN_WIDTH-1 are exact.
- Reset mid-operation: every channel returns to the reset state next cycle and any pulse is truncated.

Test Plan:
- Legacy strobe: ch0 delay=0, len=1; trigger rises at cycle 10 and is held high 5 cycles -> q[0] high only in cycle 11; busy[0] high only in cycle 11; no second pulse.
- Delay/length: ch1 delay=3, len=4; edge at cycle 20 -> q[1] high cycles 24-27, busy[1] high 21-27. Changing delay to 100 at cycle 22 has no effect.
- Ignore policy: ch2 retrigger=0, delay=2, len=5, edge at cycle 0 and again at cycle 4 -> single pulse cycles 3-7; overrun[2]=1 from cycle 5. overrun_clear pulsed at cycle 10 -> overrun[2]=0 from cycle 11.
- Restart policy: ch3 retrigger=1, delay=2, len=5, edges at cycles 0 and 4 -> q[3] high cycle 3-4, low 5-6, high 7-11; overrun[3] stays 0.
- Enable/reset: enable[0] dropped during PULSE at cycle k -> q[0]=0 from k+1. Reset asserted mid-DELAY with trigger held high -> all outputs 0; no pulse after reset releases until a new rising edge.
- Boundaries: len=0 -> one-cycle pulse. delay=65535, len=65535 -> q rises exactly 65536 cycles after the edge and lasts 65535 cycles. All four channels triggered in the same cycle -> independent, correct pulses.
